// File: rtl/ciphertext_block_buffer.sv
// Ping-pong capture buffer for streamed ciphertexts. Re-streams each stored ciphertext
// over valid/ready with last-block framing, and drops whole ciphertexts when both banks are busy.
module ciphertext_block_buffer #(
  parameter int unsigned REGISTER_SIZE = 32,
  parameter int unsigned BITS_IN_NUM   = 4096
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [REGISTER_SIZE-1:0] data_in,
  input  logic                     valid_in,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     last_out,
  output logic                     overflow_out,
  input  logic                     clear_overflow_in,
  output logic [15:0]              ct_count_out
);

  localparam int unsigned NUM_BLOCKS = 2 * BITS_IN_NUM / REGISTER_SIZE;
  localparam int unsigned IdxW       = $clog2(NUM_BLOCKS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BLOCKS - 1);

  typedef enum logic [0:0] {StIdle, StStream} rd_state_e;

  logic [REGISTER_SIZE-1:0] mem_q [2*NUM_BLOCKS];

  // Write side
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic            wr_bank_q, wr_bank_d;
  logic            drop_q, drop_d;
  logic [1:0]      full_q, full_d;
  logic            overflow_q, overflow_d;

  // Read / issue side
  rd_state_e       st_q, st_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic            rd_bank_q, rd_bank_d;
  logic            rel_bank_q, rel_bank_d;
  logic [15:0]     ct_q, ct_d;

  // Storage read register plus the two-entry output queue (output + skid)
  logic [REGISTER_SIZE-1:0] rdata_q, skid_data_q, skid_data_d, data_out_q, data_out_d;
  logic                     rvalid_q, rlast_q;
  logic                     skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
  logic                     valid_out_q, valid_out_d, last_out_q, last_out_d;

  logic       pop, rel, wr_last, tgt_busy, drop_now, dropping, store, issue, can_issue;
  logic       nxt_bank;
  logic [1:0] occ;

  assign pop      = valid_out_q & ready_in;
  assign rel      = pop & last_out_q;
  assign wr_last  = (wr_idx_q == LastIdx);
  // A bank released by this cycle's final handshake is free for a ciphertext starting now
  assign tgt_busy = full_q[wr_bank_q] & ~(rel & (rel_bank_q == wr_bank_q));
  assign drop_now = valid_in & (wr_idx_q == '0) & ~drop_q & tgt_busy;
  assign dropping = drop_q | drop_now;
  assign store    = valid_in & ~dropping;

  always_comb begin
    wr_idx_d   = wr_idx_q;
    wr_bank_d  = wr_bank_q;
    drop_d     = drop_q;
    full_d     = full_q;
    overflow_d = overflow_q;
    rel_bank_d = rel_bank_q;
    ct_d       = ct_q;
    if (rel) begin
      full_d[rel_bank_q] = 1'b0;
      rel_bank_d         = ~rel_bank_q;
      ct_d               = ct_q + 16'd1;
    end
    if (valid_in) begin
      wr_idx_d = wr_last ? '0 : wr_idx_q + 1'b1;
      if (drop_now) drop_d = 1'b1;
      if (wr_last) begin
        if (dropping) begin
          drop_d = 1'b0;
        end else begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end
    end
    if (clear_overflow_in) overflow_d = 1'b0;
    if (drop_now)          overflow_d = 1'b1;
  end

  // Issue a storage read only when the queue will have room once the read data lands
  assign occ       = 2'(valid_out_q) + 2'(skid_valid_q) + 2'(rvalid_q);
  assign can_issue = (occ - 2'(pop)) < 2'd2;
  assign nxt_bank  = ~rd_bank_q;

  always_comb begin
    st_d      = st_q;
    issue     = 1'b0;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    unique case (st_q)
      StIdle: begin
        if (full_q[rd_bank_q] && can_issue) begin
          issue = 1'b1;
          st_d  = StStream;
        end
      end
      StStream: begin
        if (can_issue) issue = 1'b1;
      end
      default: st_d = StIdle;
    endcase
    if (issue) begin
      if (rd_idx_q == LastIdx) begin
        rd_idx_d  = '0;
        rd_bank_d = nxt_bank;
        // full_d so a same-cycle release of the other bank is not mistaken for a full bank
        st_d      = full_d[nxt_bank] ? StStream : StIdle;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    data_out_d   = data_out_q;
    valid_out_d  = valid_out_q;
    last_out_d   = last_out_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    if (pop) begin
      if (skid_valid_q) begin
        data_out_d   = skid_data_q;
        last_out_d   = skid_last_q;
        skid_valid_d = rvalid_q;
        skid_data_d  = rvalid_q ? rdata_q : skid_data_q;
        skid_last_d  = rvalid_q ? rlast_q : skid_last_q;
      end else if (rvalid_q) begin
        data_out_d = rdata_q;
        last_out_d = rlast_q;
      end else begin
        valid_out_d = 1'b0;
        last_out_d  = 1'b0;
      end
    end else if (!valid_out_q) begin
      if (rvalid_q) begin
        data_out_d  = rdata_q;
        last_out_d  = rlast_q;
        valid_out_d = 1'b1;
      end
    end else if (rvalid_q) begin
      skid_data_d  = rdata_q;
      skid_last_d  = rlast_q;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_idx_q     <= '0;
      wr_bank_q    <= 1'b0;
      drop_q       <= 1'b0;
      full_q       <= '0;
      overflow_q   <= 1'b0;
      st_q         <= StIdle;
      rd_idx_q     <= '0;
      rd_bank_q    <= 1'b0;
      rel_bank_q   <= 1'b0;
      ct_q         <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      last_out_q   <= 1'b0;
    end else begin
      wr_idx_q     <= wr_idx_d;
      wr_bank_q    <= wr_bank_d;
      drop_q       <= drop_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      st_q         <= st_d;
      rd_idx_q     <= rd_idx_d;
      rd_bank_q    <= rd_bank_d;
      rel_bank_q   <= rel_bank_d;
      ct_q         <= ct_d;
      rvalid_q     <= issue;
      if (issue) begin
        rdata_q <= mem_q[{rd_bank_q, rd_idx_q}];
        rlast_q <= (rd_idx_q == LastIdx);
      end
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      last_out_q   <= last_out_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (store) mem_q[{wr_bank_q, wr_idx_q}] <= data_in;
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign last_out     = last_out_q;
  assign overflow_out = overflow_q;
  assign ct_count_out = ct_q;

endmodule

// File: tb/tb_ciphertext_block_buffer.sv
// Directed bench for ciphertext_block_buffer with 8-bit blocks, four blocks per ciphertext.
module tb_ciphertext_block_buffer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_in;
  logic        last_out;
  logic        overflow_out;
  logic        clear_overflow_in;
  logic [15:0] ct_count_out;

  int total = 0;
  int bad   = 0;

  ciphertext_block_buffer #(
    .REGISTER_SIZE(8),
    .BITS_IN_NUM  (16)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .data_in          (data_in),
    .valid_in         (valid_in),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .ready_in         (ready_in),
    .last_out         (last_out),
    .overflow_out     (overflow_out),
    .clear_overflow_in(clear_overflow_in),
    .ct_count_out     (ct_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Ciphertexts are packed little-endian: block i is w[8*i +: 8]
  task automatic send_ct(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      data_in  = w[8*i +: 8];
      valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
  endtask

  task automatic chk_blk(input string tag, input logic [7:0] d, input logic l);
    chk({tag, "_valid"}, 32'(valid_out), 32'd1);
    chk({tag, "_data"}, 32'(data_out), 32'(d));
    chk({tag, "_last"}, 32'(last_out), 32'(l));
  endtask

  // Caller holds ready_in high; waits a bounded time for the block, checks it, takes it
  task automatic take(input string tag, input logic [7:0] d, input logic l);
    int n = 0;
    while (!valid_out && n < 20) begin
      tick();
      n++;
    end
    chk_blk(tag, d, l);
    tick();
  endtask

  task automatic take_ct(input string tag, input logic [31:0] w);
    for (int i = 0; i < 4; i++) take(tag, w[8*i +: 8], i == 3);
  endtask

  initial begin
    logic [31:0] w;
    logic [6:0]  pat;
    int          k;
    int          n;

    rst_n_in = 1'b0;
    data_in = '0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    clear_overflow_in = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_last", 32'(last_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_ovf", 32'(overflow_out), 32'd0);
    chk("rst_cnt", 32'(ct_count_out), 32'd0);
    #2 rst_n_in = 1'b1;
    tick();

    // 1: single ciphertext at full throughput
    ready_in = 1'b1;
    w = 32'h44332211;
    send_ct(w);
    n = 0;
    while (!valid_out && n < 2) begin
      tick();
      n++;
    end
    chk("t1_latency", 32'(valid_out), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk_blk("t1_blk", w[8*i +: 8], i == 3);
      tick();
    end
    chk("t1_idle", 32'(valid_out), 32'd0);
    chk("t1_cnt", 32'(ct_count_out), 32'd1);

    // 2: backpressure pattern 1,0,0,1,0,1,1 (pattern bit i used in cycle i)
    ready_in = 1'b0;
    send_ct(w);
    n = 0;
    while (!valid_out && n < 20) begin
      tick();
      n++;
    end
    pat = 7'b1101001;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      ready_in = pat[i];
      chk_blk("t2_blk", w[8*k +: 8], k == 3);
      tick();
      if (pat[i]) k++;
    end
    ready_in = 1'b0;
    chk("t2_done", 32'(valid_out), 32'd0);
    chk("t2_cnt", 32'(ct_count_out), 32'd2);

    // 3: overflow with both banks held, third ciphertext dropped
    send_ct(32'ha4a3a2a1);
    send_ct(32'hb4b3b2b1);
    chk("t3_ovf_before", 32'(overflow_out), 32'd0);
    data_in  = 8'hc1;
    valid_in = 1'b1;
    tick();
    chk("t3_ovf_set", 32'(overflow_out), 32'd1);
    for (int i = 1; i < 4; i++) begin
      data_in = 8'hc1 + 8'(i);
      tick();
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    take_ct("t3_a", 32'ha4a3a2a1);
    take_ct("t3_b", 32'hb4b3b2b1);
    tick();
    tick();
    tick();
    chk("t3_c_absent", 32'(valid_out), 32'd0);
    chk("t3_cnt", 32'(ct_count_out), 32'd4);
    send_ct(32'hd4d3d2d1);
    take_ct("t3_d", 32'hd4d3d2d1);
    chk("t3_cnt_d", 32'(ct_count_out), 32'd5);
    chk("t3_ovf_sticky", 32'(overflow_out), 32'd1);

    // 6: overflow clear
    clear_overflow_in = 1'b1;
    tick();
    clear_overflow_in = 1'b0;
    chk("t6_ovf_clr", 32'(overflow_out), 32'd0);
    chk("t6_cnt", 32'(ct_count_out), 32'd5);

    // 4: next ciphertext starts on the edge of the final handshake of its target bank
    ready_in = 1'b0;
    send_ct(32'h54535251);
    send_ct(32'h64636261);
    ready_in = 1'b1;
    w = 32'h54535251;
    k = 0;
    n = 0;
    while (k < 4 && n < 30) begin
      if (valid_out) begin
        chk_blk("t4_a", w[8*k +: 8], k == 3);
        if (last_out) begin
          data_in  = 8'h71;
          valid_in = 1'b1;
        end
        k++;
      end
      tick();
      n++;
    end
    chk("t4_a_all", 32'(k), 32'd4);
    ready_in = 1'b0;
    for (int i = 1; i < 4; i++) begin
      data_in = 8'h71 + 8'(i);
      tick();
    end
    valid_in = 1'b0;
    chk("t4_ovf", 32'(overflow_out), 32'd0);
    ready_in = 1'b1;
    take_ct("t4_x", 32'h64636261);
    take_ct("t4_b", 32'h74737271);
    chk("t4_cnt", 32'(ct_count_out), 32'd8);
    chk("t4_ovf_end", 32'(overflow_out), 32'd0);

    // 5: asynchronous reset during output block 2
    send_ct(32'h84838281);
    take("t5_e", 8'h81, 1'b0);
    chk_blk("t5_e", 8'h82, 1'b0);
    tick();
    chk_blk("t5_e", 8'h83, 1'b0);
    #2 rst_n_in = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(valid_out), 32'd0);
    chk("t5_rst_cnt", 32'(ct_count_out), 32'd0);
    chk("t5_rst_data", 32'(data_out), 32'd0);
    tick();
    tick();
    #2 rst_n_in = 1'b1;
    tick();
    chk("t5_post_idle", 32'(valid_out), 32'd0);
    send_ct(32'h94939291);
    take_ct("t5_f", 32'h94939291);
    chk("t5_cnt", 32'(ct_count_out), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ciphertext_block_buffer.md
Name: ciphertext_block_buffer

Overview:
- Sits directly downstream of the per-voter encryption stage. That stage emits one ciphertext as NUM_BLOCKS consecutive REGISTER_SIZE-bit blocks, LSB block first, with a bare valid strobe and no backpressure.
- This block captures each ciphertext into a ping-pong pair of banks and re-streams it to the tally/transmit stage over a valid/ready handshake, with block framing.
- Ciphertexts that arrive while both banks are occupied are dropped and flagged.

Parameters:
- REGISTER_SIZE, 32, width of one data block.
- BITS_IN_NUM, 4096, modulus width in bits. A ciphertext is 2*BITS_IN_NUM bits.
- NUM_BLOCKS (localparam), 2*BITS_IN_NUM/REGISTER_SIZE, blocks per ciphertext. Must be ≥2 and a power of two.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- data_in  input  REGISTER_SIZE  incoming ciphertext block
- valid_in  input  1  data_in is valid this cycle. Upstream cannot stall.
- data_out  output  REGISTER_SIZE  outgoing block
- valid_out  output  1  data_out holds a valid block
- ready_in  input  1  downstream accepts data_out when valid_out && ready_in
- last_out  output  1  data_out is block NUM_BLOCKS-1 of the ciphertext
- overflow_out  output  1  sticky: at least one ciphertext was dropped
- clear_overflow_in  input  1  synchronous clear of overflow_out
- ct_count_out  output  16  count of ciphertexts fully drained, wraps at 2^16

Behaviour:
- Reset (async assert, sync release): valid_out=0, last_out=0, data_out=0, overflow_out=0, ct_count_out=0. Both banks empty. Write and read bank pointers = 0, write index = 0, drop mode off. Any in-flight data is lost.
- Write side, every valid_in cycle:
  - The block goes to the write bank at the write index, and the index increments.
  - When the index was NUM_BLOCKS-1: mark the bank full, toggle the write bank, and reset the index to 0.
- Drop rule:
  - On a valid_in with index=0 (start of a ciphertext) and the target bank still full, enter drop mode and set overflow_out.
  - In drop mode, blocks are counted but not stored. When the count reaches NUM_BLOCKS, exit drop mode; the bank is neither marked full nor toggled.
  - Drop decisions are made only at ciphertext start, never mid-ciphertext.
- Read FSM:
  - IDLE: when the read bank is full, go to STREAM.
  - STREAM: emit blocks 0..NUM_BLOCKS-1 of the read bank. On the handshake of the block with last_out=1: clear that bank's full flag, toggle the read bank, increment ct_count_out, return to IDLE. If the other bank is already full, go straight to STREAM without an idle cycle.
- Timing:
  - First valid_out is asserted no later than 2 cycles after the edge that marks the bank full.
  - With ready_in held high, blocks are emitted on consecutive cycles (full throughput despite 1-cycle storage read latency, via a prefetch/skid register).
  - While valid_out=1 && ready_in=0, data_out and last_out hold stable.
  - valid_out never drops without a handshake except on reset.
- Same-cycle release: if the final handshake releases bank B on the same edge that a new ciphertext's first block targets B, the block is accepted (release wins) with no overflow.
- Overflow flag: clear_overflow_in takes effect next edge. If it coincides with a new drop, overflow_out ends set.
- Stored data is never modified. Blocks are emitted in arrival order, bit-exact.

Test Plan (REGISTER_SIZE=8, BITS_IN_NUM=16, NUM_BLOCKS=4):
1. Single ciphertext 0x11,0x22,0x33,0x44 on 4 consecutive valid_in, ready_in=1:
   - valid_out rises ≤2 cycles after the 4th block.
   - Outputs 0x11..0x44 on 4 consecutive cycles, last_out only with 0x44.
   - ct_count_out=1.
2. Backpressure: same input, ready_in toggled 1,0,0,1,0,1,1:
   - Each block is held stable while ready_in=0.
   - Exactly 4 handshakes, order preserved, last_out on 0x44.
3. Overflow: ready_in=0, send three ciphertexts A,B,C back-to-back:
   - overflow_out=1 at C's first block.
   - After ready_in=1, output is A then B (8 blocks, C absent), ct_count_out=2.
   - Fourth ciphertext D sent after A drains is stored and emitted.
4. Same-cycle release: time B's first block to land on the edge of A's final handshake with the other bank full:
   - B is accepted, overflow_out stays 0, all blocks emitted.
5. Reset mid-stream: assert rst_n_in low asynchronously between clock edges during block 2 of output:
   - valid_out=0 immediately, ct_count_out=0.
   - After release, a fresh ciphertext streams correctly from block 0.
6. clear_overflow_in: after scenario 3, pulse clear_overflow_in for 1 cycle -> overflow_out=0 next cycle; ct_count_out unchanged.
